// File: rtl/int_stream_arbiter.sv
// ---------------------------------------------------------------------------
// int_stream_arbiter
//
// Round-robin arbiter that lets N_REQ integer-stream producers share a
// single downstream consumer. A grant is held for bursts of up to
// MAX_BURST consecutive beats, so one producer's run reaches the consumer
// without being interleaved. The output is a one-entry registered stage
// that sustains one beat per cycle while out_ready stays high.
//
// Optional build macro: INT_STREAM_ARBITER_STATS_EN
//   defined   : per-requester 32-bit transfer counters on stats, plus a
//               simulation trace line for every transfer
//   undefined : stats tied to zero, no counters
//
// Ports
//   clk        clock, all state on rising edge
//   rstn       asynchronous active-low reset
//   in_valid   per-requester valid
//   in_ready   per-requester ready (at most one high per cycle)
//   in_data    requester i data in bits [i*WIDTH +: WIDTH]
//   out_valid  output register holds a beat
//   out_ready  downstream accept
//   out_data   registered data
//   out_src    source index of out_data
//   stats      per-requester transfer counts, requester i in [i*32 +: 32]
// ---------------------------------------------------------------------------
module int_stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    localparam int SRCW     = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       in_valid,
    output logic [N_REQ-1:0]       in_ready,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRCW-1:0]        out_src,
    output logic [N_REQ*32-1:0]    stats
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]      state;
    logic [SRCW-1:0] owner;
    logic [SRCW-1:0] rr_ptr;
    logic [7:0]      burst_cnt;

    logic            vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic [SRCW-1:0] src_p1;

    logic [SRCW-1:0] grant;
    logic            grant_vld;
    logic            load_en;
    logic            xfer;
    logic            burst_last;

    // Wrap is explicit so non-power-of-two N_REQ never aliases onto an
    // index that does not exist.
    function automatic logic [SRCW-1:0] next_idx(input logic [SRCW-1:0] i);
        if (int'(i) >= N_REQ - 1)
            next_idx = '0;
        else
            next_idx = i + SRCW'(1);
    endfunction

    // ---- stage p0: grant selection -------------------------------------
    always_comb begin
        int              start;
        int              span;
        int              idx;
        logic [SRCW-1:0] cand;
        grant     = '0;
        grant_vld = 1'b0;
        start     = 0;
        span      = 0;
        idx       = 0;
        cand      = '0;
        if (state == S_BURST && in_valid[owner]) begin
            grant     = owner;
            grant_vld = 1'b1;
        end else begin
            // In BURST the owner has gone quiet: hand over immediately,
            // searching past the owner and never back onto it.
            if (state == S_BURST) begin
                start = int'(next_idx(owner));
                span  = N_REQ - 1;
            end else begin
                start = int'(rr_ptr);
                span  = N_REQ;
            end
            for (int k = 0; k < N_REQ; k++) begin
                idx = start + k;
                if (idx >= N_REQ)
                    idx = idx - N_REQ;
                cand = SRCW'(idx);
                if (!grant_vld && (k < span) && in_valid[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign load_en    = !vld_p1 || out_ready;
    assign xfer       = rstn && load_en && grant_vld;
    assign burst_last = (({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST));

    always_comb begin
        in_ready = '0;
        if (xfer)
            in_ready[grant] = 1'b1;
    end

    // ---- stage p0 -> p1: arbitration state -----------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (xfer) begin
            if (state == S_IDLE || grant != owner) begin
                if (MAX_BURST > 1) begin
                    state     <= S_BURST;
                    owner     <= grant;
                    burst_cnt <= 8'd1;
                end else begin
                    state     <= S_IDLE;
                    rr_ptr    <= next_idx(grant);
                    burst_cnt <= '0;
                end
            end else if (burst_last) begin
                state     <= S_IDLE;
                rr_ptr    <= next_idx(owner);
                burst_cnt <= '0;
            end else begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end else if (state == S_BURST && load_en && !(|in_valid)) begin
            // Nobody left to serve; release so the next requester is
            // chosen fairly from just after the old owner.
            state     <= S_IDLE;
            rr_ptr    <= next_idx(owner);
            burst_cnt <= '0;
        end
    end

    // ---- stage p1: output register -------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (xfer) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data[int'(grant)*WIDTH +: WIDTH];
            src_p1  <= grant;
        end else if (load_en) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_src   = src_p1;

`ifdef INT_STREAM_ARBITER_STATS_EN
    logic [31:0] xfer_cnt [N_REQ];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++)
                xfer_cnt[i] <= '0;
        end else if (xfer) begin
            xfer_cnt[grant] <= xfer_cnt[grant] + 32'd1;
            $display("Arb: src=%0d data=%10d", grant,
                     in_data[int'(grant)*WIDTH +: WIDTH]);
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
        assign stats[gi*32 +: 32] = xfer_cnt[gi];
    end
`else
    assign stats = '0;
`endif

endmodule

// File: doc/int_stream_arbiter.md
Name: int_stream_arbiter

Overview:
- Round-robin arbiter that shares one downstream integer consumer (accumulator-style sink) between N integer-stream producers.
- Each input is a valid/ready/data channel. Output is a single registered valid/ready/data channel tagged with the source index.
- Grant is held for bursts of up to MAX_BURST consecutive transfers per owner, so a producer's run reaches the consumer contiguously.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, data width in bits.
- MAX_BURST, 4, max consecutive transfers per grant (1..255); 1 means pure per-beat round-robin.

Ports:
- clk  input  1  clock; all state on posedge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  N_REQ  per-requester valid.
- in_ready  output  N_REQ  per-requester ready.
- in_data  input  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  registered data.
- out_src  output  SRCW  index of the source of out_data; SRCW = max(1, $clog2(N_REQ)).
- stats  output  N_REQ*32  per-requester transfer counts (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - FSM=IDLE, burst_cnt=0, rr_ptr=0 (input 0 has highest priority first).
  - in_ready=0 while rstn is low.
  - Reset mid-burst drops any held beat; it is not replayed.
- load_en = !out_valid || out_ready. This is a one-entry pipeline register with full throughput and no bubble under continuous out_ready.
- Output register:
  - When a transfer occurs, out_valid<=1, out_data<=in_data[g], out_src<=g on the next edge.
  - If load_en and no transfer occurs, out_valid<=0.
  - If out_valid && !out_ready, out_valid, out_data and out_src hold stable.
- in_ready[i] = load_en && (i == g) && in_valid[g]. At most one in_ready is high per cycle. in_ready may depend combinationally on in_valid and out_ready.
- A transfer happens when in_valid[g] && in_ready[g]. Latency from input transfer to out_valid is 1 cycle.
- Grant selection g (combinational):
  - IDLE: the first i with in_valid[i], searching from rr_ptr upward and wrapping modulo N_REQ.
  - BURST: g = owner if in_valid[owner]. Otherwise the first valid input searching from owner+1 with wrap, excluding owner. There is no idle cycle on owner release.
- FSM, evaluated only on cycles with a transfer (otherwise state holds):
  - IDLE -> BURST (owner=g, burst_cnt=1) if MAX_BURST>1.
  - IDLE -> IDLE (rr_ptr=g+1 mod N_REQ) if MAX_BURST==1.
  - BURST, g==owner:
    - burst_cnt+1 == MAX_BURST: -> IDLE, rr_ptr=owner+1 mod N_REQ, burst_cnt=0.
    - Otherwise burst_cnt++.
  - BURST, g!=owner: treat as a fresh grant to g. Owner=g, burst_cnt=1, or go to IDLE with rr_ptr=g+1 if MAX_BURST==1.
- BURST with no transfer:
  - If no input is valid and load_en: -> IDLE, rr_ptr=owner+1.
  - If !load_en: state holds; the owner keeps priority.
- Data is passed through unmodified. No arithmetic on data. burst_cnt width is 8 bits.
- If N_REQ is not a power of two, rr_ptr wrap is computed explicitly, never by truncation.

Optional Feature:
- Macro: INT_STREAM_ARBITER_STATS_EN.
- Defined:
  - Per-requester 32-bit counter increments on each transfer from that requester. Counters wrap at 2^32 to 0.
  - Counters are cleared by reset and exposed on stats[i*32 +: 32].
  - Each transfer also prints "Arb: src=%0d data=%10d" via $display.
- Undefined: stats is tied to 0, no counters are synthesized, and there is no $display.
- Arbitration behaviour is identical in both builds.

Test Plan:
- Single requester: only in_valid[0]=1 with data 0..9, out_ready=1 -> out_data 0..9 in order, out_src=0, first out_valid one cycle after the first transfer, then one beat per cycle.
- All contend: N_REQ=4, MAX_BURST=2, all valid continuously, out_ready=1 -> out_src sequence 0,0,1,1,2,2,3,3,0,0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=7 -> out_data=7 and out_src held stable, all in_ready=0. The owner keeps its burst after out_ready returns.
- Early release: owner 1 drops in_valid after 1 of 4 burst beats while 2 is valid -> input 2 granted in the same cycle, no out_valid gap, burst_cnt restarts at 1.
- Reset mid-burst: rstn low while BURST with out_valid=1 -> out_valid=0 immediately, without a clock edge. After release with all inputs valid, the first out_src=0.
- Stats (macro defined): 5 transfers from input 3, 2 from input 0 -> stats[3]=5, stats[0]=2, others 0. Without the macro, stats=0.
